spi_sp_ram: RTL and testbench

Single-port synchronous RAM that sits directly downstream of the SPI slave. It consumes the slave's 10-bit parallel words (`rx_data`/`rx_valid`) and decodes the two command bits. It stores write data and returns read data to the slave as `tx_data`/`tx_valid` for serialisation on MISO. It also flags out-of-sequence commands.

---
 rtl/spi_sp_ram.sv | 102 ++++++++++
 tb/tb_spi_sp_ram.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_sp_ram.sv
// rtl/spi_sp_ram.sv - single-port RAM behind the SPI slave, decoding 2-bit commands from 10-bit rx words
module spi_sp_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       err
);

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  logic [7:0]           mem [MEM_DEPTH];
  logic                 rx_valid_q;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 wr_addr_ok;
  logic                 rd_addr_ok;

  logic                 cmd_stb;
  cmd_e                 cmd;
  logic [ADDR_SIZE-1:0] payload_addr;
  logic                 wr_en;
  logic                 rd_en;
  logic                 reject;

  // Only the rising edge of rx_valid is a command; a held word is never replayed.
  assign cmd_stb      = rx_valid & ~rx_valid_q;
  assign cmd          = cmd_e'(din[9:8]);
  assign payload_addr = din[ADDR_SIZE-1:0];

  always_comb begin
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    reject = 1'b0;
    if (cmd_stb) begin
      case (cmd)
        CMD_WR_DATA: begin
          wr_en  = wr_addr_ok;
          reject = ~wr_addr_ok;
        end
        CMD_RD_DATA: begin
          rd_en  = rd_addr_ok;
          reject = ~rd_addr_ok;
        end
        default: ;
      endcase
    end
  end

  // Storage has no reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= din[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      wr_addr_ok <= 1'b0;
      rd_addr_ok <= 1'b0;
      dout       <= 8'h00;
      tx_valid   <= 1'b0;
      err        <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      err        <= reject;
      if (cmd_stb) begin
        tx_valid <= rd_en;
      end
      if (cmd_stb && cmd == CMD_WR_ADDR) begin
        wr_addr    <= payload_addr;
        wr_addr_ok <= 1'b1;
      end
      // Address width equals log2(MEM_DEPTH), so the increment wraps naturally.
      if (wr_en) begin
        wr_addr <= wr_addr + 1'b1;
      end
      if (cmd_stb && cmd == CMD_RD_ADDR) begin
        rd_addr    <= payload_addr;
        rd_addr_ok <= 1'b1;
      end
      if (rd_en) begin
        dout       <= mem[rd_addr];
        rd_addr_ok <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_sp_ram.sv
// tb/tb_spi_sp_ram.sv - scoreboard bench for spi_sp_ram against a command-level reference model
module tb_spi_sp_ram;

  logic       clk;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       err;

  spi_sp_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    bit         tx;
    logic [7:0] dout;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] ref_mem [256];
  int         m_wr;
  int         m_rd;
  bit         m_wr_ok;
  bit         m_rd_ok;

  task automatic model_reset();
    m_wr    = 0;
    m_rd    = 0;
    m_wr_ok = 0;
    m_rd_ok = 0;
  endtask

  // Outcome of one accepted command, as seen on the outputs the cycle after acceptance.
  task automatic model_cmd(input logic [1:0] cmd, input logic [7:0] pl);
    exp_t e;
    e.err  = 0;
    e.tx   = 0;
    e.dout = 8'h00;
    case (cmd)
      2'b00: begin m_wr = pl; m_wr_ok = 1; end
      2'b01: begin
        if (m_wr_ok) begin
          ref_mem[m_wr] = pl;
          m_wr = (m_wr + 1) % 256;
        end else e.err = 1;
      end
      2'b10: begin m_rd = pl; m_rd_ok = 1; end
      default: begin
        if (m_rd_ok) begin
          e.tx    = 1;
          e.dout  = ref_mem[m_rd];
          m_rd_ok = 0;
        end else e.err = 1;
      end
    endcase
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp_v);
    end
  endtask

  // Monitor: detects command edges on the bus, pops the scoreboard and checks outputs every cycle.
  bit         mon_prev  = 0;
  bit         acc_seen  = 0;
  bit         rst_seen  = 0;
  bit         cur_err   = 0;
  bit         cur_tx    = 0;
  logic [7:0] cur_dout  = 8'h00;

  always @(posedge clk) begin
    if (!rst_n) begin
      rst_seen = 1;
      acc_seen = 0;
      mon_prev = 0;
    end else begin
      rst_seen = 0;
      acc_seen = rx_valid && !mon_prev;
      mon_prev = rx_valid;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      cur_err  = 0;
      cur_tx   = 0;
      cur_dout = 8'h00;
    end else if (acc_seen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty at %0t: got command edge, expected none", $time);
      end else begin
        e       = exp_q.pop_front();
        cur_err = e.err;
        cur_tx  = e.tx;
        if (e.tx) cur_dout = e.dout;
      end
    end else begin
      cur_err = 0;
    end
    check("err", {7'b0, err}, {7'b0, cur_err});
    check("tx_valid", {7'b0, tx_valid}, {7'b0, cur_tx});
    check("dout", dout, cur_dout);
  end

  task automatic send(input logic [1:0] cmd, input logic [7:0] pl, input int hold = 1, input int gap = 1);
    @(negedge clk);
    din      = {cmd, pl};
    rx_valid = 1'b1;
    model_cmd(cmd, pl);
    repeat (hold - 1) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b1;
    din      = 10'h3FF;
    model_reset();
    repeat (4) @(negedge clk);
    // Released with rx_valid still high: first cycle counts as an RD_DATA edge with no address.
    rst_n = 1'b1;
    model_cmd(2'b11, 8'hFF);
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);

    send(2'b00, 8'h25);
    send(2'b01, 8'hA5);
    send(2'b10, 8'h25);
    send(2'b11, 8'h00, 1, 6);

    send(2'b00, 8'hFF);
    send(2'b01, 8'h11);
    send(2'b01, 8'h22);
    send(2'b10, 8'hFF);
    send(2'b11, 8'h00);
    send(2'b10, 8'h00);
    send(2'b11, 8'h00);

    send(2'b00, 8'h11);
    send(2'b01, 8'h00);
    send(2'b00, 8'h10);
    send(2'b01, 8'h55, 12);
    send(2'b10, 8'h10);
    send(2'b11, 8'h00);
    send(2'b10, 8'h11);
    send(2'b11, 8'h00, 1, 3);
    send(2'b11, 8'h00);

    do_reset();
    send(2'b01, 8'h77);
    send(2'b10, 8'h00);
    send(2'b11, 8'h00, 1, 4);
    do_reset();
    send(2'b11, 8'h00);

    send(2'b00, 8'h00);
    for (int i = 0; i < 256; i++) send(2'b01, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 400; i++) begin
      send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
           $urandom_range(1, 3), $urandom_range(1, 3));
    end

    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
